// File: rtl/fmul_rr_sched.sv
// Round-robin arbiter feeding one shared fixed-latency multiplier, one op per cycle, results tagged by requester.
// Accept-to-result is MUL_LAT+2 cycles; a requester is held off only while its own op is in flight, results are never stalled.
module fmul_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_x1,
  input  logic [32*N_REQ-1:0] req_x2,
  output logic [N_REQ-1:0]    req_ready,
  output logic [31:0]         mul_x1,
  output logic [31:0]         mul_x2,
  input  logic [31:0]         mul_y,
  output logic                res_valid,
  output logic [ID_W-1:0]     res_id,
  output logic [31:0]         res_y
);

  localparam int IW1 = ID_W + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] clr_mask;
  logic [ID_W-1:0]  grant_id;
  logic             found;
  logic             xfer;
  logic [31:0]      sel_x1;
  logic [31:0]      sel_x2;
  tag_t             issue;
  tag_t             tag_pipe [MUL_LAT];
  tag_t             tag_out;

  assign elig = req_valid & ~busy;

  // Search ptr, ptr+1, ... wrapping at N_REQ; first eligible index wins.
  always_comb begin
    logic [IW1-1:0] sum;
    found    = 1'b0;
    grant_id = '0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + IW1'(k);
      if (sum >= IW1'(N_REQ)) sum = sum - IW1'(N_REQ);
      if (!found && elig[sum[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = sum[ID_W-1:0];
      end
    end
  end

  assign xfer      = found & rstn;
  assign grant     = xfer ? (N_REQ'(1) << grant_id) : '0;
  assign req_ready = grant;

  always_comb begin
    sel_x1 = '0;
    sel_x2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_x1 = req_x1[32*i +: 32];
        sel_x2 = req_x2[32*i +: 32];
      end
    end
  end

  assign tag_out  = tag_pipe[MUL_LAT-1];
  assign clr_mask = tag_out.vld ? (N_REQ'(1) << tag_out.id) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr       <= '0;
      busy      <= '0;
      issue     <= '0;
      mul_x1    <= '0;
      mul_x2    <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_y     <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      issue.vld <= xfer;
      if (xfer) begin
        issue.id <= grant_id;
        mul_x1   <= sel_x1;
        mul_x2   <= sel_x2;
        ptr      <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
      end
      // Tag pipe never stalls: its last stage lines up with mul_y.
      tag_pipe[0] <= issue;
      for (int s = 1; s < MUL_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
      busy      <= (busy & ~clr_mask) | grant;
      res_valid <= tag_out.vld;
      if (tag_out.vld) begin
        res_y  <= mul_y;
        res_id <= tag_out.id;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
  a_ready_not_busy: assert property (@(posedge clk) disable iff (!rstn) (req_ready & busy) == '0);

endmodule

// File: tb/tb_fmul_rr_sched.sv
// Bench for fmul_rr_sched: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_fmul_rr_sched;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 2;
  localparam int RES_LAT = MUL_LAT + 2;

  logic                clk = 1'b0;
  logic                rstn;
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_x1;
  logic [32*N_REQ-1:0] req_x2;
  logic [N_REQ-1:0]    req_ready;
  logic [31:0]         mul_x1;
  logic [31:0]         mul_x2;
  logic [31:0]         mul_y;
  logic                res_valid;
  logic [ID_W-1:0]     res_id;
  logic [31:0]         res_y;

  always #5 clk = ~clk;

  fmul_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
    .req_ready(req_ready), .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
    .res_valid(res_valid), .res_id(res_id), .res_y(res_y)
  );

  // Simple binary32 multiply: round-to-nearest-even, flush-to-zero, overflow to inf.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [23:0] m;
    logic        g;
    logic        st;
    logic [24:0] mr;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) begin
      mr = {1'b0, m} + 25'd1;
      if (mr[24]) begin
        m = mr[24:1]; e = e + 1;
      end else begin
        m = mr[23:0];
      end
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  // Pipelined multiplier with no reset, MUL_LAT cycles from sample edge to mul_y.
  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_x1, mul_x2);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_y = mpipe[MUL_LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next cycle.
  logic             drv_rstn;
  logic [N_REQ-1:0] drv_valid;
  logic [31:0]      drv_x1 [N_REQ];
  logic [31:0]      drv_x2 [N_REQ];

  // Reference model: busy expressed as the cycle a requester becomes free, results as a due-dated queue.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } res_t;

  int          cyc;
  int          m_ptr;
  int          busy_until [N_REQ];
  res_t        rq [$];
  logic [31:0] m_mx1, m_mx2, m_ry;
  logic [31:0] m_rid;

  task automatic run_cycle();
    logic [N_REQ-1:0] exp_ready;
    int               g;
    @(posedge clk);
    #1;
    rstn      = drv_rstn;
    req_valid = drv_valid;
    for (int i = 0; i < N_REQ; i++) begin
      req_x1[32*i +: 32] = drv_x1[i];
      req_x2[32*i +: 32] = drv_x2[i];
    end
    #1;
    exp_ready = '0;
    g = -1;
    if (drv_rstn) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % N_REQ;
        if (g < 0 && drv_valid[idx] && cyc >= busy_until[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("mul_x1", mul_x1, m_mx1);
    chk("mul_x2", mul_x2, m_mx2);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(rq[0].id));
      chk("res_y", res_y, rq[0].y);
      m_rid = 32'(rq[0].id);
      m_ry  = rq[0].y;
      void'(rq.pop_front());
    end else begin
      chk("res_valid_idle", 32'(res_valid), 32'd0);
      chk("res_id_hold", 32'(res_id), m_rid);
      chk("res_y_hold", res_y, m_ry);
    end
    if (!drv_rstn) begin
      rq.delete();
      for (int i = 0; i < N_REQ; i++) busy_until[i] = 0;
      m_ptr = 0; m_mx1 = '0; m_mx2 = '0; m_rid = '0; m_ry = '0;
    end else if (g >= 0) begin
      rq.push_back('{due: cyc + RES_LAT, id: g, y: fmul(drv_x1[g], drv_x2[g])});
      busy_until[g] = cyc + RES_LAT;
      m_ptr = (g + 1) % N_REQ;
      m_mx1 = drv_x1[g];
      m_mx2 = drv_x2[g];
    end
    cyc++;
  endtask

  task automatic do_reset();
    drv_rstn  = 1'b0;
    drv_valid = '0;
    repeat (2) run_cycle();
    drv_rstn = 1'b1;
  endtask

  function automatic logic [31:0] rand_fp();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  int exp5 [6] = '{8, 1, 0, 0, 8, 1};

  initial begin
    rstn = 1'b0; req_valid = '0; req_x1 = '0; req_x2 = '0;
    drv_rstn = 1'b0; drv_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      drv_x1[i] = '0; drv_x2[i] = '0; busy_until[i] = 0;
    end
    cyc = 0; m_ptr = 0; m_mx1 = '0; m_mx2 = '0; m_rid = '0; m_ry = '0;
    repeat (3) @(posedge clk);

    // 1.5 * 2.0 from requester 0
    do_reset();
    drv_valid = 4'b0001; drv_x1[0] = 32'h3FC00000; drv_x2[0] = 32'h40000000;
    run_cycle();
    chk("t1_ready_c0", 32'(req_ready), 32'h1);
    drv_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      run_cycle();
      chk("t1_res_valid", 32'(res_valid), 32'(c == 4));
      if (c == 4) begin
        chk("t1_res_id", 32'(res_id), 32'd0);
        chk("t1_res_y", res_y, 32'h40400000);
      end
    end

    // all four requesting: rotate 0..3, results in issue order
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      drv_x1[i] = rand_fp(); drv_x2[i] = rand_fp();
    end
    drv_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      run_cycle();
      if (c < 4) chk("t2_ready", 32'(req_ready), 32'(1 << c));
      if (c == 4) chk("t2_ready_again", 32'(req_ready), 32'h1);
      if (c >= 4) begin
        chk("t2_res_valid", 32'(res_valid), 32'd1);
        chk("t2_res_id", 32'(res_id), 32'(c - 4));
      end
    end

    // single requester held: one op per RES_LAT cycles
    do_reset();
    drv_valid = 4'b0001;
    for (int c = 0; c <= 12; c++) begin
      run_cycle();
      chk("t3_ready", 32'(req_ready[0]), 32'(c % RES_LAT == 0));
      chk("t3_res_valid", 32'(res_valid), 32'(c >= RES_LAT && c % RES_LAT == 0));
    end

    // reset while requester 1 is in flight
    do_reset();
    drv_valid = 4'b0010; drv_x1[1] = 32'hC0000000; drv_x2[1] = 32'h40400000;
    for (int c = 0; c < 8; c++) begin
      drv_rstn = (c != 2);
      run_cycle();
      if (c == 0 || c == 3) chk("t4_ready", 32'(req_ready), 32'h2);
      if (c >= 3 && c <= 6) chk("t4_no_res", 32'(res_valid), 32'd0);
      if (c == 7) begin
        chk("t4_res_valid", 32'(res_valid), 32'd1);
        chk("t4_res_id", 32'(res_id), 32'd1);
        chk("t4_res_y", res_y, 32'hC0C00000);
      end
    end
    drv_rstn = 1'b1;

    // pointer wrap from requester 3 back to 0
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drv_valid = (c == 0) ? 4'b1000 : 4'b1001;
      run_cycle();
      chk("t5_ready", 32'(req_ready), 32'(exp5[c]));
    end

    // underflow result still completes the op
    do_reset();
    drv_valid = 4'b0100; drv_x1[2] = 32'h00800000; drv_x2[2] = 32'h00800000;
    for (int c = 0; c <= 4; c++) begin
      run_cycle();
      if (c == 4) begin
        chk("t6_res_valid", 32'(res_valid), 32'd1);
        chk("t6_res_id", 32'(res_id), 32'd2);
        chk("t6_res_y", res_y, 32'h00000000);
        chk("t6_ready", 32'(req_ready), 32'h4);
      end
    end

    // randomized traffic with occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drv_rstn = ($urandom_range(0, 249) != 0);
      if ((n / 500) % 2 == 0) drv_valid = 4'($urandom) | 4'($urandom);
      else drv_valid = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        drv_x1[i] = rand_fp(); drv_x2[i] = rand_fp();
      end
      run_cycle();
    end
    drv_rstn = 1'b1;
    drv_valid = '0;
    repeat (RES_LAT + 2) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
